// File: rtl/block_assembler.sv
// Serial-byte to wide-block assembler.
// Bytes are collected into an assembly register. When the final byte of a block
// arrives, the complete block moves into a separate output register, so a new
// block can start filling while the previous one is still waiting to drain.
module block_assembler #(
    parameter int BLOCK_BYTES = 16,
    parameter int MSB_FIRST   = 1,
    localparam int CW = $clog2(BLOCK_BYTES + 1),
    localparam int BW = 8 * BLOCK_BYTES
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          in_valid,
    input  logic [7:0]    in_data,
    output logic          in_ready,
    output logic          out_valid,
    output logic [BW-1:0] out_data,
    input  logic          out_ready,
    output logic [CW-1:0] fill_count
);

    localparam logic [CW-1:0] LAST_IDX = CW'(BLOCK_BYTES - 1);

    logic [BW-1:0] asm_reg;
    logic [BW-1:0] shifted;
    logic          last_byte;
    logic          accept;
    logic          drain;

    assign last_byte = (fill_count == LAST_IDX);
    assign accept    = in_valid && in_ready;
    assign drain     = out_valid && out_ready;

    // Accept a byte unless we are flushing or the last byte would overwrite an undrained block.
    always_comb begin
        in_ready = !clear && (!last_byte || !out_valid || out_ready);
    end

    // Assembly register with the incoming byte shifted in, in the configured byte order.
    always_comb begin
        shifted = '0;
        if (MSB_FIRST != 0) begin
            shifted = {asm_reg[BW-9:0], in_data};
        end else begin
            shifted = {in_data, asm_reg[BW-1:8]};
        end
    end

    // Partial-block state: clear flushes it, the final byte empties it for the next block.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            asm_reg    <= '0;
            fill_count <= '0;
        end else if (clear) begin
            asm_reg    <= '0;
            fill_count <= '0;
        end else if (accept) begin
            if (last_byte) begin
                asm_reg    <= '0;
                fill_count <= '0;
            end else begin
                asm_reg    <= shifted;
                fill_count <= fill_count + CW'(1);
            end
        end
    end

    // Output buffer: a newly completed block wins over a drain on the same edge, so no bubble.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (accept && last_byte) begin
            out_valid <= 1'b1;
            out_data  <= shifted;
        end else if (drain) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_block_assembler.sv
// Bench for block_assembler: table vectors, directed corner sequences and a random run,
// all compared against a queue-based reference model of the block assembly rules.
module tb_block_assembler;

    localparam int N  = 16;
    localparam int BW = 8 * N;
    localparam int CW = $clog2(N + 1);

    logic          clk = 1'b0;
    logic          reset;
    logic          clear;
    logic          in_valid;
    logic [7:0]    in_data;
    logic          out_ready;
    logic          in_ready, in_ready_l;
    logic          out_valid, out_valid_l;
    logic [BW-1:0] out_data, out_data_l;
    logic [CW-1:0] fill_count, fill_count_l;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    block_assembler #(.BLOCK_BYTES(N), .MSB_FIRST(1)) dut (
        .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
        .out_ready(out_ready), .fill_count(fill_count)
    );

    block_assembler #(.BLOCK_BYTES(N), .MSB_FIRST(0)) dut_l (
        .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready_l), .out_valid(out_valid_l), .out_data(out_data_l),
        .out_ready(out_ready), .fill_count(fill_count_l)
    );

    // Reference model: bytes of the partial block in arrival order, plus the output buffer.
    logic [7:0]    q[$];
    logic          m_ov;
    logic [BW-1:0] m_od;
    logic [BW-1:0] m_odl;
    logic          rdy_seen;

    task automatic check(input string name, input logic [BW-1:0] got, input logic [BW-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Byte i of a block sits in the top byte lane (msb order) or lane i (lsb order).
    function automatic logic [BW-1:0] build(input bit msb);
        logic [BW-1:0] r;
        r = '0;
        for (int i = 0; i < N; i++) begin
            if (msb) r[BW-1-8*i -: 8] = q[i];
            else     r[8*i +: 8]      = q[i];
        end
        return r;
    endfunction

    task automatic model_reset();
        q.delete();
        m_ov  = 1'b0;
        m_od  = '0;
        m_odl = '0;
    endtask

    task automatic step(input logic iv, input logic [7:0] d, input logic clr, input logic ordy);
        logic exp_rdy;
        logic acc;
        in_valid  = iv;
        in_data   = d;
        clear     = clr;
        out_ready = ordy;
        #1;
        exp_rdy  = !clr && ((q.size() != N - 1) || !m_ov || ordy);
        rdy_seen = in_ready;
        check("in_ready", BW'(in_ready), BW'(exp_rdy));
        check("in_ready_lsb", BW'(in_ready_l), BW'(exp_rdy));
        @(posedge clk);
        acc = iv && exp_rdy;
        if (m_ov && ordy) m_ov = 1'b0;
        if (clr) begin
            q.delete();
        end else if (acc) begin
            q.push_back(d);
            if (q.size() == N) begin
                m_od  = build(1'b1);
                m_odl = build(1'b0);
                m_ov  = 1'b1;
                q.delete();
            end
        end
        #1;
        check("out_valid", BW'(out_valid), BW'(m_ov));
        check("out_valid_lsb", BW'(out_valid_l), BW'(m_ov));
        check("out_data", out_data, m_od);
        check("out_data_lsb", out_data_l, m_odl);
        check("fill_count", BW'(fill_count), BW'(q.size()));
        check("fill_count_lsb", BW'(fill_count_l), BW'(q.size()));
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    typedef struct {
        logic       iv;
        logic [7:0] d;
        logic       clr;
        logic       ordy;
        logic       exp_rdy;
        logic       exp_ov;
        int         exp_fill;
    } vec_t;

    vec_t vecs[8];

    initial begin
        vecs[0] = '{1'b1, 8'hA0, 1'b0, 1'b1, 1'b1, 1'b0, 1};
        vecs[1] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1};
        vecs[2] = '{1'b1, 8'hA1, 1'b1, 1'b1, 1'b0, 1'b0, 0};
        vecs[3] = '{1'b1, 8'hA2, 1'b0, 1'b0, 1'b1, 1'b0, 1};
        vecs[4] = '{1'b1, 8'hA3, 1'b0, 1'b0, 1'b1, 1'b0, 2};
        vecs[5] = '{1'b0, 8'hA4, 1'b1, 1'b0, 1'b0, 1'b0, 0};
        vecs[6] = '{1'b1, 8'hA5, 1'b0, 1'b1, 1'b1, 1'b0, 1};
        vecs[7] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1};

        reset = 1'b1; clear = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
        model_reset();
        #1;
        check("rst_out_valid", BW'(out_valid), '0);
        check("rst_out_data", out_data, '0);
        check("rst_fill", BW'(fill_count), '0);
        check("rst_in_ready", BW'(in_ready), BW'(1));
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Table vectors
        for (int i = 0; i < 8; i++) begin
            step(vecs[i].iv, vecs[i].d, vecs[i].clr, vecs[i].ordy);
            check("vec_rdy", BW'(rdy_seen), BW'(vecs[i].exp_rdy));
            check("vec_ov", BW'(out_valid), BW'(vecs[i].exp_ov));
            check("vec_fill", BW'(fill_count), BW'(vecs[i].exp_fill));
        end

        // Back-to-back 0x00..0x0F, both byte orders, single-cycle out_valid pulse
        pulse_reset();
        for (int i = 0; i < N; i++) step(1'b1, 8'(i), 1'b0, 1'b1);
        check("blk_msb", out_data, 128'h000102030405060708090A0B0C0D0E0F);
        check("blk_lsb", out_data_l, 128'h0F0E0D0C0B0A09080706050403020100);
        check("blk_ov", BW'(out_valid), BW'(1));
        step(1'b0, 8'h00, 1'b0, 1'b1);
        check("blk_ov_pulse", BW'(out_valid), '0);

        // Stall on the final byte while the first block is undrained
        pulse_reset();
        for (int i = 0; i < 32; i++) step(1'b1, 8'(8'h20 + i), 1'b0, 1'b0);
        check("stall_rdy", BW'(rdy_seen), '0);
        check("stall_fill", BW'(fill_count), BW'(15));
        check("stall_hold", out_data, 128'h202122232425262728292A2B2C2D2E2F);
        step(1'b1, 8'h3F, 1'b0, 1'b1);
        check("swap_rdy", BW'(rdy_seen), BW'(1));
        check("swap_ov", BW'(out_valid), BW'(1));
        check("swap_blk2", out_data, 128'h303132333435363738393A3B3C3D3E3F);

        // Clear mid-block drops the offered byte and leaves the output alone
        for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h50 + i), 1'b0, 1'b0);
        step(1'b1, 8'h99, 1'b1, 1'b0);
        check("clr_rdy", BW'(rdy_seen), '0);
        check("clr_fill", BW'(fill_count), '0);
        check("clr_out_kept", out_data, 128'h303132333435363738393A3B3C3D3E3F);
        check("clr_ov_kept", BW'(out_valid), BW'(1));
        for (int i = 0; i < N; i++) step(1'b1, 8'(8'h60 + i), 1'b0, 1'b1);
        check("clr_next_blk", out_data, 128'h606162636465666768696A6B6C6D6E6F);
        check("clr_next_fill", BW'(fill_count), '0);

        // Continuous 48-byte stream with out_ready held high
        pulse_reset();
        for (int k = 1; k <= 48; k++) begin
            step(1'b1, 8'(k), 1'b0, 1'b1);
            check("stream_rdy", BW'(rdy_seen), BW'(1));
            check("stream_ov_slot", BW'(out_valid), BW'((k % N) == 0));
        end

        // Asynchronous reset at fill 9 with a block pending
        pulse_reset();
        for (int i = 0; i < N + 9; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
        check("pre_arst_fill", BW'(fill_count), BW'(9));
        check("pre_arst_ov", BW'(out_valid), BW'(1));
        #2;
        reset = 1'b1;
        #1;
        check("arst_ov", BW'(out_valid), '0);
        check("arst_data", out_data, '0);
        check("arst_fill", BW'(fill_count), '0);
        check("arst_rdy", BW'(in_ready), BW'(1));
        reset = 1'b0;
        model_reset();
        for (int i = 0; i < N; i++) step(1'b1, 8'(8'h70 + i), 1'b0, 1'b1);
        check("arst_next_blk", out_data, 128'h707172737475767778797A7B7C7D7E7F);
        check("arst_next_ov", BW'(out_valid), BW'(1));

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            step(1'($urandom_range(0, 3) != 0), 8'($urandom), 1'($urandom_range(0, 15) == 0),
                 1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
